periph_router: RTL and testbench
================================

Name: periph_router

Overview:
- Host-side counterpart of the per-peripheral block. Sits between the USB FIFO bridge and the NUM_PERIPHS peripheral instances.
- Downstream (host to peripheral) path:
  - Buffers one host packet.
  - Broadcasts it on the shared tx bus, flow-controlled by the addressed peripheral's tx_full and ready.
- Upstream (peripheral to host) path:
  - Round-robin arbitrates the peripherals' rx FIFOs.
  - Accounts for the 1-cycle FIFO read latency.
  - Presents one registered packet at a time to the host.

Parameters:
- NUM_PERIPHS, 4, number of attached peripherals; legal range 1..2**ADDR_WIDTH.
- PACKET_WIDTH, 32, packet width; equals usb_packet_width.
- ADDR_WIDTH, 3, address field width in packet bits [PACKET_WIDTH-1 -: ADDR_WIDTH]; equals periph_address_width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- host_tx_data  in  PACKET_WIDTH  packet from host; top ADDR_WIDTH bits are the destination address.
- host_tx_valid  in  1  host_tx_data valid.
- host_tx_ready  out  1  router accepts host_tx_data this cycle.
- periph_tx_data  out  PACKET_WIDTH  broadcast tx bus to all peripherals.
- periph_tx_valid  out  1  single-cycle write strobe; the addressed peripheral captures the packet.
- periph_tx_full  in  NUM_PERIPHS  per-peripheral tx FIFO full.
- periph_ready  in  NUM_PERIPHS  per-peripheral post-reset ready.
- periph_rx_data  in  NUM_PERIPHS*PACKET_WIDTH  concatenated rx FIFO outputs; peripheral i occupies slice i.
- periph_rx_empty  in  NUM_PERIPHS  per-peripheral rx FIFO empty.
- periph_rx_read  out  NUM_PERIPHS  one-hot rx FIFO read enable.
- host_rx_data  out  PACKET_WIDTH  packet to host.
- host_rx_valid  out  1  host_rx_data valid.
- host_rx_ready  in  1  host accepts host_rx_data.
- drop_count  out  16  count of dropped host packets.

Behaviour:
- Reset values:
  - All outputs 0.
  - Tx stage empty; rx FSM in SCAN; rr_ptr = 0.
  - Reset mid-operation discards any held packet with no partial strobe.
- Tx stage (S) registers and pop rule:
  - S holds one packet (s_data, s_valid).
  - Define a = s_data address.
  - host_tx_ready = ~s_valid | s_pop.
  - Load S when host_tx_valid & host_tx_ready.
- Tx stage forwarding:
  - If s_valid & a < NUM_PERIPHS & periph_ready[a] & ~periph_tx_full[a]:
    - periph_tx_valid = 1 (combinational, same cycle); s_pop = 1.
    - periph_tx_data = s_data at all times.
  - If s_valid & a >= NUM_PERIPHS: drop, meaning s_pop = 1, periph_tx_valid = 0, and a drop increment.
  - If s_valid & peripheral not ready or full: stall, holding S with host_tx_ready = 0.
  - Sustained throughput is 1 packet/cycle with load and pop in the same cycle.
  - periph_tx_valid is never high for 2 cycles on the same packet.
- Rx FSM, states SCAN, WAIT, PRESENT:
  - SCAN:
    - Search circularly from rr_ptr for the first i with ~periph_rx_empty[i] & periph_ready[i].
    - If found: periph_rx_read[i] = 1 for this cycle only (combinational), grant <= i, go to WAIT.
    - If none found, stay in SCAN.
  - WAIT:
    - FIFO dout is valid this cycle.
    - host_rx_data <= periph_rx_data slice[grant].
    - rr_ptr <= (grant == NUM_PERIPHS-1) ? 0 : grant+1.
    - Go to PRESENT.
  - PRESENT:
    - host_rx_valid = 1 and host_rx_data is held stable.
    - On host_rx_ready, go to SCAN.
  - periph_rx_read is 0 outside SCAN; at most one bit is high.
  - Minimum 3 cycles/packet.
  - A peripheral cannot be granted twice in a row while another requests.
- Rx address field: passed through unmodified, since the peripheral inserts it.
- drop_count:
  - 16-bit, saturates at 0xFFFF.
  - Only present with the optional feature.

Optional Feature:
- Macro: PERIPH_ROUTER_DROP_CNT_EN.
- Defined: drop_count is implemented as above.
- Undefined:
  - No counter register; drop_count is tied to 0.
  - Drop behaviour is unchanged: an unmapped packet is still consumed in 1 cycle.

Test Plan:
- Reset, then host sends 0x2000_00AA (addr 1) with periph_ready = 4'hF -> periph_tx_valid high exactly 1 cycle, same cycle S is valid; periph_tx_data = 0x2000_00AA.
- periph_tx_full[2] = 1 and host sends addr 2 packet then addr 0 packet -> host_tx_ready = 0 while stalled; release full after 5 cycles -> addr 2 packet is written, then the addr 0 packet, in order.
- NUM_PERIPHS = 4 and host sends 0xE000_0001 (addr 7) three times -> no periph_tx_valid; drop_count = 3 with macro, 0 without.
- periph_rx_empty = 4'b0000 with each FIFO returning a distinct packet and host_rx_ready = 1 -> grants in order 0, 1, 2, 3, 0; periph_rx_read pulses spaced 3 cycles apart; host_rx_data matches the slice read 1 cycle after each read.
- host_rx_ready = 0 for 10 cycles in PRESENT -> host_rx_data is stable and there is no periph_rx_read; on ready, the next read occurs in the following cycle.
- Assert rst during WAIT -> next cycle host_rx_valid = 0, FSM in SCAN, rr_ptr = 0, and no read strobe during reset.

Source files
------------

// File: rtl/periph_router.sv
`default_nettype none
// ============================================================================
// Module   : periph_router
// Brief    : Host-side router. Buffers one host packet onto the shared
//            peripheral tx bus and round-robin arbitrates the peripheral rx
//            FIFOs back to the host. PERIPH_ROUTER_DROP_CNT_EN enables the
//            saturating drop_count register.
// Revision : 1.0
// ============================================================================
module periph_router #(
  parameter int NUM_PERIPHS  = 4,
  parameter int PACKET_WIDTH = 32,
  parameter int ADDR_WIDTH   = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PACKET_WIDTH-1:0]         host_tx_data,
  input  logic                            host_tx_valid,
  output logic                            host_tx_ready,
  output logic [PACKET_WIDTH-1:0]         periph_tx_data,
  output logic                            periph_tx_valid,
  input  logic [NUM_PERIPHS-1:0]          periph_tx_full,
  input  logic [NUM_PERIPHS-1:0]          periph_ready,
  input  logic [NUM_PERIPHS*PACKET_WIDTH-1:0] periph_rx_data,
  input  logic [NUM_PERIPHS-1:0]          periph_rx_empty,
  output logic [NUM_PERIPHS-1:0]          periph_rx_read,
  output logic [PACKET_WIDTH-1:0]         host_rx_data,
  output logic                            host_rx_valid,
  input  logic                            host_rx_ready,
  output logic [15:0]                     drop_count
);

  localparam int PTR_W = (NUM_PERIPHS > 1) ? $clog2(NUM_PERIPHS) : 1;
  localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_PERIPHS - 1);

  // ---------------- downstream tx stage ----------------
  logic [PACKET_WIDTH-1:0] r_s_data;
  logic                    r_s_valid;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [NUM_PERIPHS-1:0]  w_addr_oh;
  logic                    w_mapped;
  logic                    w_fwd;
  logic                    w_drop;
  logic                    w_pop;

  assign w_addr = r_s_data[PACKET_WIDTH-1 -: ADDR_WIDTH];

  always_comb begin
    w_addr_oh = '0;
    for (int i = 0; i < NUM_PERIPHS; i++)
      w_addr_oh[i] = (w_addr == ADDR_WIDTH'(i));
  end

  // An address with no matching one-hot bit is unmapped and gets dropped.
  assign w_mapped        = |w_addr_oh;
  assign w_fwd           = r_s_valid & (|(w_addr_oh & periph_ready & ~periph_tx_full));
  assign w_drop          = r_s_valid & ~w_mapped;
  assign w_pop           = w_fwd | w_drop;
  assign periph_tx_valid = w_fwd;
  assign periph_tx_data  = r_s_data;
  assign host_tx_ready   = ~rst & (~r_s_valid | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
    end else if (host_tx_valid && host_tx_ready) begin
      r_s_valid <= 1'b1;
      r_s_data  <= host_tx_data;
    end else if (w_pop) begin
      r_s_valid <= 1'b0;
    end
  end

`ifdef PERIPH_ROUTER_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = '0;
`endif

  // ---------------- upstream rx arbiter ----------------
  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } rx_state_t;

  rx_state_t               r_state;
  rx_state_t               w_state_nxt;
  logic [PTR_W-1:0]        r_rr_ptr;
  logic [PTR_W-1:0]        r_grant;
  logic [PTR_W-1:0]        w_pick;
  logic [PTR_W-1:0]        w_hi_pick;
  logic [PTR_W-1:0]        w_lo_pick;
  logic                    w_hi_found;
  logic                    w_lo_found;
  logic [NUM_PERIPHS-1:0]  w_req;
  logic [NUM_PERIPHS-1:0]  w_rd;
  logic [PACKET_WIDTH-1:0] r_rx_data;
  logic [PACKET_WIDTH-1:0] w_rx_sel;

  assign w_req = ~periph_rx_empty & periph_ready;

  // Circular search: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_pick  = '0;
    w_lo_pick  = '0;
    for (int i = NUM_PERIPHS - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_lo_found = 1'b1;
        w_lo_pick  = PTR_W'(i);
        if (PTR_W'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_pick  = PTR_W'(i);
        end
      end
    end
    w_pick = w_hi_found ? w_hi_pick : w_lo_pick;
  end

  always_comb begin
    w_rx_sel = '0;
    for (int i = 0; i < NUM_PERIPHS; i++)
      if (r_grant == PTR_W'(i))
        w_rx_sel = periph_rx_data[i*PACKET_WIDTH +: PACKET_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= SCAN;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = '0;
    case (r_state)
      SCAN: begin
        if (w_lo_found) begin
          w_rd        = NUM_PERIPHS'(1) << w_pick;
          w_state_nxt = WAIT;
        end
      end
      WAIT:    w_state_nxt = PRESENT;
      PRESENT: if (host_rx_ready) w_state_nxt = SCAN;
      default: w_state_nxt = SCAN;
    endcase
  end

  // FIFO dout lags the read strobe by one cycle, so data is captured in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_rx_data <= '0;
    end else begin
      if ((r_state == SCAN) && w_lo_found)
        r_grant <= w_pick;
      if (r_state == WAIT) begin
        r_rx_data <= w_rx_sel;
        r_rr_ptr  <= (r_grant == c_last_idx) ? '0 : r_grant + PTR_W'(1);
      end
    end
  end

  assign periph_rx_read = rst ? '0 : w_rd;
  assign host_rx_valid  = (r_state == PRESENT);
  assign host_rx_data   = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_periph_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_periph_router
// Brief    : Directed bench for periph_router with a cycle-level reference
//            model compared on every falling edge.
// Revision : 1.0
// ============================================================================
module tb_periph_router;

  localparam int N  = 4;
  localparam int PW = 32;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [PW-1:0]   host_tx_data;
  logic            host_tx_valid;
  logic            host_tx_ready;
  logic [PW-1:0]   periph_tx_data;
  logic            periph_tx_valid;
  logic [N-1:0]    periph_tx_full;
  logic [N-1:0]    periph_ready;
  logic [N*PW-1:0] periph_rx_data;
  logic [N-1:0]    periph_rx_empty;
  logic [N-1:0]    periph_rx_read;
  logic [PW-1:0]   host_rx_data;
  logic            host_rx_valid;
  logic            host_rx_ready;
  logic [15:0]     drop_count;

  periph_router #(.NUM_PERIPHS(N), .PACKET_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .host_tx_data    (host_tx_data),
    .host_tx_valid   (host_tx_valid),
    .host_tx_ready   (host_tx_ready),
    .periph_tx_data  (periph_tx_data),
    .periph_tx_valid (periph_tx_valid),
    .periph_tx_full  (periph_tx_full),
    .periph_ready    (periph_ready),
    .periph_rx_data  (periph_rx_data),
    .periph_rx_empty (periph_rx_empty),
    .periph_rx_read  (periph_rx_read),
    .host_rx_data    (host_rx_data),
    .host_rx_valid   (host_rx_valid),
    .host_rx_ready   (host_rx_ready),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] tx_log[$];
  int          rd_idx[$];
  int          rd_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rx_pkt(input int i);
    return (32'(i) << 29) | (32'h00C0_DE00 + 32'(i));
  endfunction

  // Reference model: spec-level state (held packet, rx phase, pointers).
  logic        m_s_valid;
  logic [31:0] m_s_data;
  int          m_phase;   // 0 scan, 1 wait, 2 present
  int          m_grant;
  int          m_rr;
  logic [31:0] m_rx;
  int          m_drop;

  always @(negedge clk) begin
    int          a;
    int          pick;
    logic        e_txv;
    logic        e_htr;
    logic        drop;
    logic [N-1:0] e_rd;
    logic [15:0] e_drop;
    cyc++;
    if (rst) begin
      m_s_valid = 1'b0; m_s_data = '0; m_phase = 0; m_grant = 0;
      m_rr = 0; m_rx = '0; m_drop = 0;
      check("rst_host_tx_ready", {31'b0, host_tx_ready}, 32'd0);
      check("rst_periph_tx_valid", {31'b0, periph_tx_valid}, 32'd0);
      check("rst_periph_rx_read", {28'b0, periph_rx_read}, 32'd0);
      check("rst_host_rx_valid", {31'b0, host_rx_valid}, 32'd0);
      check("rst_host_rx_data", host_rx_data, 32'd0);
      check("rst_drop_count", {16'b0, drop_count}, 32'd0);
    end else begin
      a     = int'(m_s_data >> (PW - AW));
      e_txv = m_s_valid && (a < N) && periph_ready[a % N] && !periph_tx_full[a % N];
      drop  = m_s_valid && (a >= N);
      e_htr = !m_s_valid || e_txv || drop;
      e_rd  = '0;
      pick  = -1;
      if (m_phase == 0)
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (pick < 0 && !periph_rx_empty[idx] && periph_ready[idx]) pick = idx;
        end
      if (pick >= 0) e_rd[pick] = 1'b1;
`ifdef PERIPH_ROUTER_DROP_CNT_EN
      e_drop = 16'(m_drop);
`else
      e_drop = 16'd0;
`endif
      check("host_tx_ready", {31'b0, host_tx_ready}, {31'b0, e_htr});
      check("periph_tx_valid", {31'b0, periph_tx_valid}, {31'b0, e_txv});
      check("periph_tx_data", periph_tx_data, m_s_data);
      check("periph_rx_read", {28'b0, periph_rx_read}, {28'b0, e_rd});
      check("host_rx_valid", {31'b0, host_rx_valid}, {31'b0, (m_phase == 2)});
      check("host_rx_data", host_rx_data, m_rx);
      check("drop_count", {16'b0, drop_count}, {16'b0, e_drop});

      if (periph_tx_valid === 1'b1) tx_log.push_back(periph_tx_data);
      for (int i = 0; i < N; i++)
        if (periph_rx_read[i] === 1'b1) begin
          rd_idx.push_back(i);
          rd_cyc.push_back(cyc);
        end

      if (host_tx_valid && e_htr) begin
        m_s_valid = 1'b1;
        m_s_data  = host_tx_data;
      end else if (e_txv || drop) begin
        m_s_valid = 1'b0;
      end
      if (drop && m_drop < 65535) m_drop++;
      case (m_phase)
        0: if (pick >= 0) begin m_grant = pick; m_phase = 1; end
        1: begin
          m_rx    = periph_rx_data[m_grant*PW +: PW];
          m_rr    = (m_grant + 1) % N;
          m_phase = 2;
        end
        default: if (host_rx_ready) m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    host_tx_valid = 1'b1;
    host_tx_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = host_tx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    host_tx_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted data=%h", d);
    end
  endtask

  task automatic wait_reads(input int target);
    int n;
    n = 0;
    while (rd_idx.size() < target && n < 100) begin
      tick();
      n++;
    end
    if (rd_idx.size() < target) begin
      checks++;
      failures++;
      $display("FAIL read_timeout actual=%0d expected=%0d", rd_idx.size(), target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    rst             = 1'b1;
    host_tx_data    = '0;
    host_tx_valid   = 1'b0;
    periph_tx_full  = '0;
    periph_ready    = 4'hF;
    periph_rx_empty = 4'hF;
    host_rx_ready   = 1'b1;
    for (int i = 0; i < N; i++) periph_rx_data[i*PW +: PW] = rx_pkt(i);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single forward to addr 1
    send(32'h2000_00AA);
    repeat (2) tick();
    check("fwd_count", tx_log.size(), 32'd1);
    check("fwd_data", tx_log[0], 32'h2000_00AA);

    // Stall on full peripheral 2, then in-order release
    periph_tx_full = 4'b0100;
    send(32'h4000_0002);
    fork
      send(32'h0000_0003);
      begin
        repeat (5) tick();
        periph_tx_full = '0;
      end
    join
    repeat (3) tick();
    check("stall_count", tx_log.size(), 32'd3);
    check("stall_first", tx_log[1], 32'h4000_0002);
    check("stall_second", tx_log[2], 32'h0000_0003);

    // Unmapped address 7 is dropped three times
    repeat (3) send(32'hE000_0001);
    repeat (2) tick();
    check("drop_no_write", tx_log.size(), 32'd3);
`ifdef PERIPH_ROUTER_DROP_CNT_EN
    check("drop_total", {16'b0, drop_count}, 32'd3);
`else
    check("drop_total", {16'b0, drop_count}, 32'd0);
`endif

    // Round robin over all four rx FIFOs
    periph_rx_empty = 4'b0000;
    wait_reads(5);
    periph_rx_empty = 4'hF;
    repeat (4) tick();
    for (int k = 0; k < 5; k++) check("rr_grant", rd_idx[k], k % 4);
    for (int k = 1; k < 5; k++) check("rr_spacing", rd_cyc[k] - rd_cyc[k-1], 32'd3);
    check("rr_last_data", host_rx_data, 32'h00C0_DE00);

    // Host backpressure in PRESENT
    host_rx_ready   = 1'b0;
    periph_rx_empty = 4'b0000;
    wait_reads(6);
    check("bp_grant", rd_idx[5], 32'd1);
    tick();
    @(negedge clk);
    held = host_rx_data;
    check("bp_data", held, 32'h20C0_DE01);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      check("bp_valid", {31'b0, host_rx_valid}, 32'd1);
      check("bp_stable", host_rx_data, held);
      check("bp_no_read", {28'b0, periph_rx_read}, 32'd0);
    end
    @(posedge clk);
    #1;
    host_rx_ready = 1'b1;
    @(negedge clk);
    check("bp_release_hold", {28'b0, periph_rx_read}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_next_read", {28'b0, periph_rx_read}, 32'b0100);

    // Reset while in WAIT
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("wrst_valid", {31'b0, host_rx_valid}, 32'd0);
    check("wrst_read", {28'b0, periph_rx_read}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("wrst_rr_zero", {28'b0, periph_rx_read}, 32'b0001);
    @(posedge clk);
    #1;
    periph_rx_empty = 4'hF;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
